// File: rtl/dct4_stream_pipe.sv
// dct4_stream_pipe: streaming 4-point integer DCT (coefficients 64/80/36).
// Gathers four signed samples from a valid/ready stream, runs a butterfly
// stage (S1) and a shift-and-add product stage (S2), and presents all four
// coefficients in parallel on a registered valid/ready output. Framing errors
// (in_last misplaced) raise a one-cycle err_align pulse.
module dct4_stream_pipe #(
  parameter  int IN_W      = 8,
  parameter  int OUT_SHIFT = 0,
  localparam int OUT_W     = IN_W + 8 - OUT_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y0,
  output logic signed [OUT_W-1:0] y1,
  output logic signed [OUT_W-1:0] y2,
  output logic signed [OUT_W-1:0] y3,
  output logic                    err_align
);

  localparam int AW = IN_W + 1;
  localparam int FW = IN_W + 9;
  localparam logic signed [FW-1:0] RND = FW'((1 << OUT_SHIFT) >> 1);

  logic        [1:0]       r_idx;
  logic signed [IN_W-1:0]  r_x0, r_x1, r_x2;
  logic                    r_err;
  logic                    r_s1_valid;
  logic signed [AW-1:0]    r_a0, r_a1, r_b0, r_b1;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_y0, r_y1, r_y2, r_y3;

  logic                    w_s2_adv, w_s1_ready, w_accept, w_fourth;
  logic signed [FW-1:0]    w_a0e, w_a1e, w_b0e, w_b1e;
  logic signed [FW-1:0]    w_p0, w_p1, w_p2, w_p3;
  logic signed [OUT_W-1:0] w_y0, w_y1, w_y2, w_y3;

  // The 4th sample may only enter when S1 can take it, so in_ready depends
  // on registered state and out_ready only, never on in_valid.
  assign w_s2_adv   = !r_out_valid || out_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_adv;
  assign in_ready   = (r_idx != 2'd3) || w_s1_ready;
  assign w_accept   = in_valid && in_ready;
  assign w_fourth   = w_accept && (r_idx == 2'd3);

  // Sign-extend butterfly terms to a width where the products cannot overflow.
  assign w_a0e = FW'(r_a0);
  assign w_a1e = FW'(r_a1);
  assign w_b0e = FW'(r_b0);
  assign w_b1e = FW'(r_b1);

  // Products from shifts and adds: 64 = 2^6, 80 = 2^6 + 2^4, 36 = 2^5 + 2^2.
  assign w_p0 = (w_a0e + w_a1e) <<< 6;
  assign w_p2 = (w_a0e - w_a1e) <<< 6;
  assign w_p1 = (w_b0e <<< 6) + (w_b0e <<< 4) + (w_b1e <<< 5) + (w_b1e <<< 2);
  assign w_p3 = (w_b0e <<< 5) + (w_b0e <<< 2) - (w_b1e <<< 6) - (w_b1e <<< 4);

  // Round-half-up scaling; RND is zero when no shift is requested.
  assign w_y0 = OUT_W'((w_p0 + RND) >>> OUT_SHIFT);
  assign w_y1 = OUT_W'((w_p1 + RND) >>> OUT_SHIFT);
  assign w_y2 = OUT_W'((w_p2 + RND) >>> OUT_SHIFT);
  assign w_y3 = OUT_W'((w_p3 + RND) >>> OUT_SHIFT);

  // Gather samples x0..x2, track block position and flag framing errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= 2'd0;
      r_x0  <= '0;
      r_x1  <= '0;
      r_x2  <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_accept) begin
        if (r_idx == 2'd3) begin
          r_idx <= 2'd0;
          r_err <= !in_last;
        end else if (in_last) begin
          r_idx <= 2'd0;
          r_err <= 1'b1;
        end else begin
          case (r_idx)
            2'd0:    r_x0 <= in_data;
            2'd1:    r_x1 <= in_data;
            default: r_x2 <= in_data;
          endcase
          r_idx <= r_idx + 2'd1;
        end
      end
    end
  end

  // S1 butterfly: loads directly from the 4th sample plus the gathered three.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_a0       <= '0;
      r_a1       <= '0;
      r_b0       <= '0;
      r_b1       <= '0;
    end else if (w_fourth) begin
      r_s1_valid <= 1'b1;
      r_a0       <= AW'(r_x0) + AW'(in_data);
      r_a1       <= AW'(r_x1) + AW'(r_x2);
      r_b0       <= AW'(r_x0) - AW'(in_data);
      r_b1       <= AW'(r_x1) - AW'(r_x2);
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  // S2 output register: advances when empty or being consumed, else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_y0        <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_y3        <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y0 <= w_y0;
        r_y1 <= w_y1;
        r_y2 <= w_y2;
        r_y3 <= w_y3;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y0        = r_y0;
  assign y1        = r_y1;
  assign y2        = r_y2;
  assign y3        = r_y3;
  assign err_align = r_err;

endmodule
